// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter that time-shares one multiplier among num_req_p requesters.
// One operation is in flight at a time; the product is routed back to its issuer.
module mul_share_arbiter #(
  parameter int width_p    = 4,
  parameter int num_req_p  = 4,
  parameter int id_width_p = $clog2(num_req_p)
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic [num_req_p-1:0]           req_valid_i,
  output logic [num_req_p-1:0]           req_ready_o,
  input  logic [num_req_p*width_p-1:0]   req_a_i,
  input  logic [num_req_p*width_p-1:0]   req_b_i,
  output logic [num_req_p-1:0]           resp_valid_o,
  input  logic [num_req_p-1:0]           resp_ready_i,
  output logic [2*width_p-1:0]           resp_result_o,
  output logic                           mul_valid_o,
  input  logic                           mul_ready_i,
  output logic [width_p-1:0]             mul_a_o,
  output logic [width_p-1:0]             mul_b_o,
  input  logic                           mul_valid_i,
  output logic                           mul_ready_o,
  input  logic [2*width_p-1:0]           mul_result_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                            state_q, state_d;
  logic [id_width_p-1:0]             owner_q, rr_ptr_q, grant_id;
  logic                              grant_vld;
  logic [width_p-1:0]                a_q, b_q;
  logic [2*width_p-1:0]              res_q;
  logic [num_req_p-1:0][width_p-1:0] req_a, req_b;
  logic [num_req_p-1:0]              one_hot;
  logic                              resp_acc;

  assign req_a    = req_a_i;
  assign req_b    = req_b_i;
  assign one_hot  = {{(num_req_p-1){1'b0}}, 1'b1};
  assign resp_acc = resp_ready_i[owner_q];

  // Scan starts at rr_ptr so the last-served requester is checked last.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    for (int i = 0; i < num_req_p; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (!grant_vld && req_valid_i[idx]) begin
        grant_vld = 1'b1;
        grant_id  = id_width_p'(idx);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_vld)   state_d = ISSUE;
      ISSUE:   if (mul_ready_i) state_d = WAIT;
      WAIT:    if (mul_valid_i) state_d = RESP;
      RESP:    if (resp_acc)    state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o  = '0;
    resp_valid_o = '0;
    mul_valid_o  = 1'b0;
    mul_ready_o  = 1'b0;
    case (state_q)
      IDLE:    if (grant_vld) req_ready_o = one_hot << grant_id;
      ISSUE:   mul_valid_o  = 1'b1;
      WAIT:    mul_ready_o  = 1'b1;
      RESP:    resp_valid_o = one_hot << owner_q;
      default: ;
    endcase
  end

  assign mul_a_o       = a_q;
  assign mul_b_o       = b_q;
  assign resp_result_o = res_q;

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      if (state_q == IDLE && grant_vld) begin
        a_q     <= req_a[grant_id];
        b_q     <= req_b[grant_id];
        owner_q <= grant_id;
      end
      if (state_q == WAIT && mul_valid_i) res_q <= mul_result_i;
      if (state_q == RESP && resp_acc)
        rr_ptr_q <= (owner_q == id_width_p'(num_req_p-1)) ? '0 : owner_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter; the bench plays the multiplier and all requesters.
module tb_mul_share_arbiter;
  localparam int W = 4;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             reset_ni;
  logic [N-1:0]     req_valid_i, req_ready_o, resp_valid_o, resp_ready_i;
  logic [N*W-1:0]   req_a_i, req_b_i;
  logic [2*W-1:0]   resp_result_o, mul_result_i;
  logic             mul_valid_o, mul_ready_i, mul_valid_i, mul_ready_o;
  logic [W-1:0]     mul_a_o, mul_b_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mul_share_arbiter #(.width_p(W), .num_req_p(N)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_result_o(resp_result_o),
    .mul_valid_o(mul_valid_o), .mul_ready_i(mul_ready_i),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i), .mul_ready_o(mul_ready_o),
    .mul_result_i(mul_result_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a_i[k*W +: W] = a;
    req_b_i[k*W +: W] = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready_o),   0);
    chk({tag, "_resp_valid"}, 32'(resp_valid_o),  0);
    chk({tag, "_mul_valid"},  32'(mul_valid_o),   0);
    chk({tag, "_mul_ready"},  32'(mul_ready_o),   0);
    chk({tag, "_mul_a"},      32'(mul_a_o),       0);
    chk({tag, "_mul_b"},      32'(mul_b_o),       0);
    chk({tag, "_result"},     32'(resp_result_o), 0);
  endtask

  // Entered at a negedge in IDLE with requests already driven; returns at a negedge in IDLE.
  // bp: cycles of resp_ready_i=0, then 2 cycles of 'wrong', then 'ack'.
  task automatic run_op(input string tag, input int k, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp, input int lat,
                        input int bp, input logic [N-1:0] wrong, input logic [N-1:0] ack);
    logic [N-1:0] oh;
    oh = N'(1) << k;
    #1;
    chk({tag, "_grant"}, 32'(req_ready_o), 32'(oh));
    @(negedge clk);
    chk({tag, "_issue_valid"}, 32'(mul_valid_o), 1);
    chk({tag, "_issue_a"},     32'(mul_a_o), 32'(a));
    chk({tag, "_issue_b"},     32'(mul_b_o), 32'(b));
    @(negedge clk);
    chk({tag, "_issue_hold"},  32'(mul_valid_o), 1);
    chk({tag, "_issue_noreq"}, 32'(req_ready_o), 0);
    mul_ready_i = 1'b1;
    @(negedge clk);
    mul_ready_i = 1'b0;
    chk({tag, "_wait_ready"}, 32'(mul_ready_o), 1);
    chk({tag, "_wait_valid"}, 32'(mul_valid_o), 0);
    repeat (lat) @(negedge clk);
    mul_valid_i  = 1'b1;
    mul_result_i = {4'b0, a} * {4'b0, b};
    @(negedge clk);
    mul_valid_i  = 1'b0;
    mul_result_i = '0;
    resp_ready_i = '0;
    for (int i = 0; i < bp; i++) begin
      chk({tag, "_bp_valid"},  32'(resp_valid_o), 32'(oh));
      chk({tag, "_bp_result"}, 32'(resp_result_o), 32'(exp));
      chk({tag, "_bp_nogrant"}, 32'(req_ready_o), 0);
      @(negedge clk);
    end
    if (wrong != '0) begin
      resp_ready_i = wrong;
      repeat (2) begin
        @(negedge clk);
        chk({tag, "_wrong_valid"}, 32'(resp_valid_o), 32'(oh));
      end
    end
    chk({tag, "_resp_valid"},  32'(resp_valid_o), 32'(oh));
    chk({tag, "_resp_result"}, 32'(resp_result_o), 32'(exp));
    resp_ready_i = ack;
    @(negedge clk);
    resp_ready_i = '0;
    chk({tag, "_idle"}, 32'(resp_valid_o), 0);
  endtask

  initial begin
    reset_ni = 1'b0; req_valid_i = '0; req_a_i = '0; req_b_i = '0;
    resp_ready_i = '0; mul_ready_i = 1'b0; mul_valid_i = 1'b0; mul_result_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    reset_ni = 1'b1;

    // 1: single request
    set_ops(0, 3, 5); req_valid_i = 4'b0001;
    run_op("single", 0, 3, 5, 15, 2, 0, 4'b0000, 4'b0001);
    req_valid_i = '0;
    #1 chk("single_back_idle", 32'(req_ready_o), 0);

    // 2: round robin, everyone valid (rr_ptr is 1 after serving 0 above; re-reset)
    reset_ni = 1'b0; @(negedge clk); reset_ni = 1'b1;
    for (int k = 0; k < N; k++) set_ops(k, W'(k+1), 2);
    req_valid_i = 4'b1111;
    run_op("rr0", 0, 1, 2, 2, 0, 0, 4'b0000, 4'b1111);
    run_op("rr1", 1, 2, 2, 4, 1, 0, 4'b0000, 4'b1111);
    run_op("rr2", 2, 3, 2, 6, 0, 0, 4'b0000, 4'b1111);
    run_op("rr3", 3, 4, 2, 8, 3, 0, 4'b0000, 4'b1111);
    run_op("rr4", 0, 1, 2, 2, 0, 0, 4'b0000, 4'b1111);

    // 3: pointer skip — after 1 is served, 3 precedes 0
    req_valid_i = 4'b0010; set_ops(1, 6, 3);
    run_op("skip1", 1, 6, 3, 18, 0, 0, 4'b0000, 4'b0010);
    req_valid_i = 4'b1001; set_ops(0, 7, 7); set_ops(3, 5, 3);
    run_op("skip3", 3, 5, 3, 15, 1, 0, 4'b0000, 4'b1000);
    req_valid_i = 4'b0001;
    run_op("skip0", 0, 7, 7, 49, 0, 0, 4'b0000, 4'b0001);

    // 4: response backpressure with wrong-requester ready
    req_valid_i = 4'b0100; set_ops(2, 15, 15);
    run_op("bp", 2, 15, 15, 225, 1, 5, 4'b0001, 4'b0100);

    // 5: zero and edge operands
    req_valid_i = 4'b0010; set_ops(1, 0, 9);
    run_op("zero", 1, 0, 9, 0, 0, 0, 4'b0000, 4'b0010);
    set_ops(1, 15, 1);
    run_op("edge", 1, 15, 1, 15, 2, 0, 4'b0000, 4'b0010);

    // 6: reset while in WAIT
    req_valid_i = 4'b0100; set_ops(2, 5, 5);
    @(negedge clk);
    req_valid_i = '0;
    mul_ready_i = 1'b1;
    @(negedge clk);
    mul_ready_i = 1'b0;
    chk("rst_in_wait", 32'(mul_ready_o), 1);
    reset_ni = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    chk_all_zero("rst_mid");
    mul_valid_i = 1'b1; mul_result_i = 8'd25;
    @(negedge clk);
    mul_valid_i = 1'b0; mul_result_i = '0;
    chk("rst_no_resp", 32'(resp_valid_o), 0);
    req_valid_i = 4'b0001; set_ops(0, 2, 7);
    run_op("post_rst", 0, 2, 7, 14, 1, 0, 4'b0000, 4'b0001);
    req_valid_i = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Round-robin arbiter sharing one multiplier instance (valid/ready in, valid/ready out, 2*width_p result) among num_req_p requesters.
- Accepts one operand pair at a time and sequences it through the multiplier.
- Returns the product to the requester that issued it.
- Sits between client blocks and the single multiplier; at most one operation is outstanding.

Parameters:
- width_p, 4, operand width; product width is 2*width_p.
- num_req_p, 4, number of requesters (>=2).
- id_width_p, $clog2(num_req_p), width of the internal owner ID.

Ports:
- clk_i  input  1  clock; all logic on posedge.
- reset_ni  input  1  reset, synchronous, active-low.
- req_valid_i  input  num_req_p  per-requester operand valid.
- req_ready_o  output  num_req_p  per-requester accept; at most one bit set.
- req_a_i  input  num_req_p*width_p  packed operand A; requester k at bits [k*width_p +: width_p].
- req_b_i  input  num_req_p*width_p  packed operand B; same packing.
- resp_valid_o  output  num_req_p  per-requester result valid; at most one bit set.
- resp_ready_i  input  num_req_p  per-requester result accept.
- resp_result_o  output  2*width_p  product, shared by all requesters.
- mul_valid_o  output  1  to multiplier valid_i.
- mul_ready_i  input  1  from multiplier ready_o.
- mul_a_o  output  width_p  to multiplier a_i.
- mul_b_o  output  width_p  to multiplier b_i.
- mul_valid_i  input  1  from multiplier valid_o.
- mul_ready_o  output  1  to multiplier ready_i.
- mul_result_i  input  2*width_p  from multiplier result_o.

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP. Registers: owner ID, latched A and B, latched result, round-robin pointer rr_ptr.

Reset (reset_ni=0 at a posedge):
- State goes to IDLE and rr_ptr to 0.
- A, B, result and owner registers clear to 0.
- All outputs are 0 on the following cycle: req_ready_o, resp_valid_o, mul_valid_o, mul_ready_o, mul_a_o, mul_b_o, resp_result_o.
- Reset mid-operation abandons the operation. No response is ever produced for it.
- If the multiplier is left holding a result, it is not drained. The system resets both blocks together.

IDLE:
- Grant goes to the first requester k with req_valid_i[k]=1, scanning from rr_ptr upward modulo num_req_p.
- req_ready_o[k]=1 combinationally for the winner only. All other bits are 0.
- On the clock edge with a grant: latch req_a/b slice k and owner=k, then go to ISSUE.
- No valid requester: stay in IDLE with req_ready_o all 0.

ISSUE:
- mul_valid_o=1, with mul_a_o and mul_b_o driven from the latched registers and held stable.
- On mul_ready_i=1: go to WAIT.
- Otherwise hold ISSUE with all values unchanged.

WAIT:
- mul_ready_o=1 and mul_valid_o=0.
- On mul_valid_i=1: latch mul_result_i and go to RESP.

RESP:
- resp_valid_o[owner]=1, resp_result_o = latched product, stable until accepted.
- On resp_ready_i[owner]=1: go to IDLE and set rr_ptr = (owner+1) mod num_req_p.
- resp_ready_i on non-owner bits is ignored.

Outside IDLE:
- req_ready_o=0.
- Requesters must hold valid and operands until granted. The arbiter does not sample them.

Other rules:
- resp_result_o reads 0 after reset. Between operations it holds the last product, which is don't-care when resp_valid_o=0.
- Latency from grant to resp_valid_o = 1 (ISSUE) + multiplier cycles in WAIT + 1.
- Throughput is one operation per (latency+1) cycles. No overlap between operations.

Fairness:
- A requester that stays valid is granted within num_req_p operations.
- A requester that was just served has the lowest priority at the next IDLE.

Test Plan:
1. Single request, no contention:
   - Stimulus: reset 2 cycles; req_valid_i=4'b0001, A=3, B=5.
   - Required: req_ready_o=4'b0001 in IDLE; mul_a_o=3 and mul_b_o=5 with mul_valid_o=1; resp_valid_o=4'b0001 and resp_result_o=15 after the multiplier finishes; back to IDLE after resp_ready_i[0]=1.
2. Round-robin contention:
   - Stimulus: all four requesters continuously valid with A=k+1, B=2; resp_ready_i all 1.
   - Required: grants in order 0,1,2,3,0; results 2,4,6,8,2.
3. Pointer skip:
   - Stimulus: after serving requester 1, only requesters 0 and 3 are valid.
   - Required: requester 3 is granted before 0.
4. Response backpressure:
   - Stimulus: A=15, B=15 from requester 2; resp_ready_i=0 for 5 cycles, then 1.
   - Required: resp_valid_o=4'b0100 and resp_result_o=225 stable for all 5 cycles; no new grant until acceptance; wrong-requester ready (resp_ready_i=4'b0001) has no effect.
5. Zero and edge operands:
   - Stimulus: A=0, B=9, then A=15, B=1.
   - Required: results 0 and 15; no hang.
6. Reset mid-operation:
   - Stimulus: reset_ni=0 for 1 cycle while in WAIT.
   - Required: next cycle all outputs 0 and state IDLE; a new request A=2, B=7 from requester 0 completes with result 14.
